// File: rtl/spi_pkg.sv
// Shared encodings and word-length helpers for the SPI target core.
package spi_pkg;

  localparam logic [1:0] MODE_0 = 2'b00;
  localparam logic [1:0] MODE_1 = 2'b01;
  localparam logic [1:0] MODE_2 = 2'b10;
  localparam logic [1:0] MODE_3 = 2'b11;

  localparam logic [1:0] LEN_8  = 2'b00;
  localparam logic [1:0] LEN_16 = 2'b01;
  localparam logic [1:0] LEN_24 = 2'b10;
  localparam logic [1:0] LEN_32 = 2'b11;

  typedef enum logic [1:0] {
    ST_WAIT_HI = 2'd0,
    ST_IDLE    = 2'd1,
    ST_SHIFT   = 2'd2
  } spi_state_e;

  function automatic logic [5:0] word_bits(input logic [1:0] len);
    return ({4'd0, len} + 6'd1) << 3;
  endfunction

  // Index of the first (most significant) bit of a word: N-1.
  function automatic logic [4:0] word_top(input logic [1:0] len);
    return {len, 3'b111};
  endfunction

  function automatic logic [31:0] word_mask(input logic [1:0] len);
    return 32'hFFFF_FFFF >> (6'd32 - word_bits(len));
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer for one SPI pin with rise/fall detection in the GCLK domain.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Chain resets low so a CS held low across reset never looks high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave_core.sv
// SPI target core: modes 0-3, 8/16/24/32-bit words, back-to-back words per CS frame.
// Optional `SPI_SLV_FRAME_ERR_EN adds frame_err_out, pulsing when CS aborts a partial word.
module spi_slave_core
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        GCLK,
  input  logic        RST,
  input  logic [1:0]  spi_mode_in,
  input  logic [1:0]  word_len_in,
  input  logic [31:0] tx_data_in,
  input  logic        tx_load_in,
  output logic        tx_ready_out,
  output logic [31:0] rx_data_out,
  output logic        rx_valid_out,
  output logic        busy_out,
`ifdef SPI_SLV_FRAME_ERR_EN
  output logic        frame_err_out,
`endif
  input  logic        SCLK_in,
  input  logic        CS_in,
  input  logic        MOSI_in,
  output logic        MISO_out,
  output logic        MISO_oe_out
);

  spi_state_e  state_q, state_d;
  logic [1:0]  mode_q, len_q;
  logic [4:0]  bit_cnt_q;
  logic [31:0] rx_sh_q, tx_sh_q, tx_buf_q, rx_data_q;
  logic        tx_full_q, miso_q, done_q, rx_valid_q;

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(GCLK), .rst(RST), .din(SCLK_in), .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(GCLK), .rst(RST), .din(CS_in), .level(cs_lvl), .rise(cs_rise), .fall(cs_fall));
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(GCLK), .rst(RST), .din(MOSI_in), .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall));

  logic        in_shift, lead_edge, trail_edge, sample_evt, shift_evt;
  logic        frame_start, last_bit, word_end, consume, accept, abort;
  logic [4:0]  top_idx, new_top_idx;
  logic [31:0] tx_word;

  assign in_shift    = (state_q == ST_SHIFT);
  assign lead_edge   = mode_q[1] ? sclk_fall : sclk_rise;
  assign trail_edge  = mode_q[1] ? sclk_rise : sclk_fall;
  assign sample_evt  = in_shift & (mode_q[0] ? trail_edge : lead_edge);
  assign shift_evt   = in_shift & (mode_q[0] ? lead_edge : trail_edge);
  assign frame_start = (state_q == ST_IDLE) & cs_fall;
  assign top_idx     = word_top(len_q);
  assign new_top_idx = word_top(word_len_in);
  assign last_bit    = (bit_cnt_q == top_idx);
  assign word_end    = sample_evt & last_bit;
  assign consume     = frame_start | word_end;
  assign accept      = tx_load_in & ~tx_full_q;
  assign tx_word     = tx_full_q ? tx_buf_q : '0;
  // A CS rise in the same cycle as the final sample lets the word complete.
  assign abort       = in_shift & cs_rise & (bit_cnt_q != 5'd0) & ~word_end;

  always_ff @(posedge GCLK) begin
    if (RST) state_q <= ST_WAIT_HI;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT_HI: if (cs_lvl)  state_d = ST_IDLE;
      ST_IDLE:    if (cs_fall) state_d = ST_SHIFT;
      ST_SHIFT:   if (cs_rise) state_d = ST_IDLE;
      default:                 state_d = ST_WAIT_HI;
    endcase
  end

  // Shift datapath; the next TX word is loaded on the sample edge that ends a word.
  always_ff @(posedge GCLK) begin
    if (RST) begin
      mode_q    <= MODE_0;
      len_q     <= LEN_8;
      bit_cnt_q <= '0;
      rx_sh_q   <= '0;
      tx_sh_q   <= '0;
      miso_q    <= 1'b0;
    end else begin
      if (frame_start) begin
        mode_q    <= spi_mode_in;
        len_q     <= word_len_in;
        bit_cnt_q <= '0;
        if (spi_mode_in[0]) begin
          tx_sh_q <= tx_word;
          miso_q  <= 1'b0;
        end else begin
          tx_sh_q <= tx_word << 1;
          miso_q  <= tx_word[new_top_idx];
        end
      end
      if (sample_evt) begin
        rx_sh_q   <= {rx_sh_q[30:0], mosi_lvl};
        bit_cnt_q <= last_bit ? 5'd0 : bit_cnt_q + 5'd1;
        if (last_bit) tx_sh_q <= tx_word;
      end
      if (shift_evt) begin
        miso_q  <= tx_sh_q[top_idx];
        tx_sh_q <= tx_sh_q << 1;
      end
    end
  end

  always_ff @(posedge GCLK) begin
    if (RST) begin
      tx_full_q <= 1'b0;
      tx_buf_q  <= '0;
    end else begin
      if (consume) tx_full_q <= 1'b0;
      if (accept) begin
        tx_full_q <= 1'b1;
        tx_buf_q  <= tx_data_in;
      end
    end
  end

  always_ff @(posedge GCLK) begin
    if (RST) begin
      done_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      done_q     <= word_end;
      rx_valid_q <= done_q;
      if (done_q) rx_data_q <= rx_sh_q & word_mask(len_q);
    end
  end

`ifdef SPI_SLV_FRAME_ERR_EN
  logic frame_err_q;
  always_ff @(posedge GCLK) begin
    if (RST) frame_err_q <= 1'b0;
    else     frame_err_q <= abort;
  end
  assign frame_err_out = frame_err_q;
  logic unused_sig;
  assign unused_sig = ^{sclk_lvl, mosi_rise, mosi_fall};
`else
  logic unused_sig;
  assign unused_sig = ^{sclk_lvl, mosi_rise, mosi_fall, abort};
`endif

  assign tx_ready_out = ~tx_full_q;
  assign rx_data_out  = rx_data_q;
  assign rx_valid_out = rx_valid_q;
  assign busy_out     = in_shift;
  assign MISO_oe_out  = in_shift;
  assign MISO_out     = in_shift & miso_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: SPI master driver tasks, reference model of expected words, rx scoreboard.
module tb_spi_slave_core;

  localparam int H = 8;  // GCLK cycles per SCLK half period

  logic        GCLK = 1'b0;
  logic        RST;
  logic [1:0]  spi_mode_in, word_len_in;
  logic [31:0] tx_data_in;
  logic        tx_load_in;
  logic        tx_ready_out;
  logic [31:0] rx_data_out;
  logic        rx_valid_out, busy_out;
  logic        SCLK_in, CS_in, MOSI_in, MISO_out, MISO_oe_out;
`ifdef SPI_SLV_FRAME_ERR_EN
  logic        frame_err_out;
`endif

  spi_slave_core #(.SYNC_STAGES(2)) dut (
    .GCLK(GCLK), .RST(RST), .spi_mode_in(spi_mode_in), .word_len_in(word_len_in),
    .tx_data_in(tx_data_in), .tx_load_in(tx_load_in), .tx_ready_out(tx_ready_out),
    .rx_data_out(rx_data_out), .rx_valid_out(rx_valid_out), .busy_out(busy_out),
`ifdef SPI_SLV_FRAME_ERR_EN
    .frame_err_out(frame_err_out),
`endif
    .SCLK_in(SCLK_in), .CS_in(CS_in), .MOSI_in(MOSI_in),
    .MISO_out(MISO_out), .MISO_oe_out(MISO_oe_out));

  // Clock and watchdog
  always #5 GCLK = ~GCLK;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp = 32'h0;
  logic [1:0]  cur_mode;
  int          cur_nb;
  int          err_exp = 0;
  int          err_seen = 0;
  logic        prev_valid = 1'b0;

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] nb_mask(input int nb);
    logic [31:0] one = 32'd1;
    return (nb >= 32) ? 32'hFFFF_FFFF : ((one << nb) - 32'd1);
  endfunction

  // Scoreboard monitor
  always @(negedge GCLK) begin
    if (!RST) begin
      if (prev_valid) check("rx_valid_pulse_width", 32'(rx_valid_out), 32'd0);
      if (rx_valid_out && !prev_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rx_unexpected: got word %h expected no rx_valid", rx_data_out);
        end else begin
          check("rx_data", rx_data_out, exp_q.pop_front());
        end
      end
`ifdef SPI_SLV_FRAME_ERR_EN
      if (frame_err_out) err_seen++;
`endif
    end
    prev_valid = RST ? 1'b0 : rx_valid_out;
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge GCLK);
    #2;
  endtask

  task automatic tx_load(input logic [31:0] v);
    tx_data_in = v;
    tx_load_in = 1'b1;
    tick(1);
    tx_load_in = 1'b0;
    tx_data_in = $urandom;
    check("tx_ready_after_load", 32'(tx_ready_out), 32'd0);
  endtask

  task automatic frame_begin(input logic [1:0] mode, input logic [1:0] len);
    spi_mode_in = mode;
    word_len_in = len;
    SCLK_in = mode[1];
    tick(H);
    cur_mode = mode;
    cur_nb = 8 * (int'(len) + 1);
    CS_in = 1'b0;
  endtask

  task automatic send_bit(input logic b, output logic m);
    if (!cur_mode[0]) begin
      MOSI_in = b;
      tick(H);
      m = MISO_out;
      SCLK_in = ~SCLK_in;
      tick(H);
      SCLK_in = ~SCLK_in;
    end else begin
      tick(H);
      SCLK_in = ~SCLK_in;
      MOSI_in = b;
      tick(H);
      m = MISO_out;
      SCLK_in = ~SCLK_in;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input logic [31:0] exp_miso, input bit scramble);
    logic [31:0] got = 32'h0;
    logic m;
    exp_q.push_back(w & nb_mask(cur_nb));
    for (int i = cur_nb - 1; i >= 0; i--) begin
      send_bit(w[i], m);
      got = {got[30:0], m};
      if (i == cur_nb - 1) begin
        check("busy_in_frame", 32'(busy_out), 32'd1);
        check("miso_oe_in_frame", 32'(MISO_oe_out), 32'd1);
        if (scramble) begin
          spi_mode_in = 2'($urandom);
          word_len_in = 2'($urandom);
        end
      end
    end
    check("miso_word", got, exp_miso & nb_mask(cur_nb));
    last_exp = w & nb_mask(cur_nb);
  endtask

  task automatic frame_end();
    tick(H);
    CS_in = 1'b1;
    tick(3 * H);
    check("busy_after_frame", 32'(busy_out), 32'd0);
    check("miso_idle_after_frame", {30'd0, MISO_oe_out, MISO_out}, 32'd0);
  endtask

  task automatic run_frame(input logic [1:0] mode, input logic [1:0] len, input int nw,
                           input bit do_load, input logic [31:0] txv, input bit scramble);
    if (do_load) tx_load(txv);
    frame_begin(mode, len);
    for (int k = 0; k < nw; k++)
      send_word($urandom, (k == 0 && do_load) ? txv : 32'h0, scramble && (k == 0));
    frame_end();
    check("tx_ready_after_frame", 32'(tx_ready_out), 32'd1);
  endtask

  initial begin
    logic m;
    RST = 1'b1;
    CS_in = 1'b1;
    SCLK_in = 1'b0;
    MOSI_in = 1'b0;
    spi_mode_in = 2'b00;
    word_len_in = 2'b00;
    tx_data_in = 32'h0;
    tx_load_in = 1'b0;
    tick(5);
    check("rst_tx_ready", 32'(tx_ready_out), 32'd1);
    check("rst_rx_data", rx_data_out, 32'd0);
    check("rst_rx_valid", 32'(rx_valid_out), 32'd0);
    check("rst_busy", 32'(busy_out), 32'd0);
    check("rst_miso", {30'd0, MISO_oe_out, MISO_out}, 32'd0);
`ifdef SPI_SLV_FRAME_ERR_EN
    check("rst_frame_err", 32'(frame_err_out), 32'd0);
`endif
    RST = 1'b0;
    tick(2 * H);

    // Mode 0, 8-bit
    tx_load(32'h3C);
    frame_begin(2'b00, 2'b00);
    send_word(32'hA5, 32'h3C, 1'b0);
    frame_end();

    // Mode 3, 32-bit
    tx_load(32'h1234_5678);
    frame_begin(2'b11, 2'b11);
    send_word(32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
    frame_end();

    // Mode 1, 16-bit, two words, single TX load
    tx_load(32'h0000_5A5A);
    frame_begin(2'b01, 2'b01);
    send_word(32'h1234, 32'h5A5A, 1'b0);
    send_word(32'hC3C3, 32'h0000, 1'b0);
    frame_end();

    // Mode 2, 8-bit, CS raised after 5 bits
    frame_begin(2'b10, 2'b00);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom), m);
    frame_end();
    err_exp++;
    check("rx_hold_after_abort", rx_data_out, last_exp);

    // Reset while CS is low mid-frame
    tx_load(32'hFF);
    frame_begin(2'b00, 2'b00);
    for (int i = 0; i < 3; i++) send_bit(1'($urandom), m);
    RST = 1'b1;
    tick(3);
    RST = 1'b0;
    tick(1);
    check("midrst_tx_ready", 32'(tx_ready_out), 32'd1);
    check("midrst_rx_data", rx_data_out, 32'd0);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom), m);
    check("midrst_busy_ignored", 32'(busy_out), 32'd0);
    frame_end();
    last_exp = 32'h0;
    run_frame(2'b00, 2'b00, 1, 1'b1, 32'h69, 1'b0);

    // Mode/length inputs changed mid-frame
    tx_load(32'h81);
    frame_begin(2'b00, 2'b00);
    send_word(32'h96, 32'h81, 1'b1);
    frame_end();

    // Randomized frames
    for (int f = 0; f < 12; f++)
      run_frame(2'($urandom), 2'($urandom), int'($urandom_range(1, 3)),
                1'($urandom), $urandom, 1'($urandom));

    tick(4 * H);
    check("rx_pending_at_end", 32'(exp_q.size()), 32'd0);
`ifdef SPI_SLV_FRAME_ERR_EN
    check("frame_err_count", 32'(err_seen), 32'(err_exp));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
